cfs_apb_master: RTL and testbench
=================================

CFS_APB_MASTER -- requirements
Module: cfs_apb_master

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 16, width of paddr and cmd_addr.
REQ-002 Parameter APB_DATA_WIDTH, default 32, width of pwdata, prdata, cmd_wdata and rsp_rdata.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles without pready; 0 disables the timeout.
REQ-004 pclk  input  1  single clock; all logic on its rising edge.
REQ-005 preset  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  transfer request valid.
REQ-007 cmd_ready  output  1  request accepted when high together with cmd_valid.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  APB_ADDR_WIDTH  byte address, passed to paddr unmodified.
REQ-010 cmd_wdata  input  APB_DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  response valid.
REQ-012 rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 rsp_rdata  output  APB_DATA_WIDTH  read data; 0 for writes, errors and timeouts.
REQ-014 rsp_err  output  1  set if pslverr was sampled or a timeout occurred.
REQ-015 rsp_timeout  output  1  set if the transfer was aborted by the timeout.
REQ-016 The APB outputs SHALL be paddr (APB_ADDR_WIDTH), pwrite (1), psel (1), penable (1) and pwdata (APB_DATA_WIDTH).
REQ-017 The APB inputs SHALL be pready (1), prdata (APB_DATA_WIDTH) and pslverr (1).

Function
REQ-018 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP.
REQ-019 cmd_ready SHALL equal (state == IDLE).
REQ-020 In IDLE, when cmd_valid is high, the block SHALL register cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata, and go to SETUP.
REQ-021 In SETUP (exactly 1 cycle): psel=1, penable=0; the FSM SHALL then go to ACCESS.
REQ-022 In ACCESS: psel=1, penable=1; paddr, pwrite and pwdata SHALL be held stable.
REQ-023 In ACCESS with pready=1, the block SHALL capture prdata (reads only, else 0) and pslverr into rsp_rdata and rsp_err, clear rsp_timeout, and go to RESP.
REQ-024 In ACCESS, prdata and pslverr SHALL be ignored in any cycle where pready=0.
REQ-025 The timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-026 When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), the block SHALL abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
REQ-027 If pready=1 in the same cycle the counter reaches its limit, the block SHALL treat it as normal completion; pready wins.
REQ-028 In RESP: psel=0, penable=0, rsp_valid=1; response fields SHALL be held stable until rsp_ready.
REQ-029 On rsp_ready in RESP, the FSM SHALL go to IDLE.
REQ-030 Minimum command-to-command period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP) with pready and rsp_ready tied high.
REQ-031 Latency from cmd acceptance to rsp_valid SHALL be 2 + (number of ACCESS wait cycles) cycles.
REQ-032 paddr, pwrite and pwdata SHALL retain their last values outside a transfer.
REQ-033 psel SHALL never be high in IDLE or RESP, and penable SHALL never be high without psel.
REQ-034 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.

Reset
REQ-035 While preset=1 at a rising pclk edge, the block SHALL enter IDLE, regardless of the current state (including mid-ACCESS).
REQ-036 Reset SHALL clear psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the timeout counter to 0.
REQ-037 cmd_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-038 Package cfs_apb_master_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS/RESP) and the default width constants.
REQ-039 No sub-module is required; the FSM and timeout counter SHALL live in cfs_apb_master.

Verification
REQ-040 Write, cmd_addr=0x0000, cmd_wdata=0x0000_0102, pready high in first ACCESS cycle -> psel rises 1 cycle after accept, penable 1 cycle later; rsp_valid 3 cycles after accept with rsp_err=0.
REQ-041 Read, cmd_addr=0x000C, slave returns prdata=0x0000_0305 after 2 wait cycles -> rsp_rdata=0x0000_0305 and rsp_err=0; paddr stable for all 3 ACCESS cycles.
REQ-042 Write, cmd_addr=0x0004, slave returns pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-043 pready held 0, TIMEOUT_CYCLES=16 -> psel drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1.
REQ-044 rsp_ready held low 5 cycles with cmd_valid high -> rsp fields stable, cmd_ready=0 throughout, no new SETUP until after the handshake.
REQ-045 preset=1 during ACCESS -> psel=0, penable=0, rsp_valid=0 next cycle; the next command completes normally.

Source files
------------

// File: rtl/cfs_apb_master_pkg.sv
// Shared types and default sizing for the command-to-APB bridge.
// Holds the transfer FSM state encoding and the counter width helper.
package cfs_apb_master_pkg;

    localparam int DEFAULT_ADDR_WIDTH     = 16;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // The counter must be able to hold TIMEOUT_CYCLES itself; never narrower than one bit.
    function automatic int timeout_cnt_width(input int timeout_cycles);
        return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/cfs_apb_master.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer out,
// one response back, with an optional ACCESS-phase timeout.
module cfs_apb_master
    import cfs_apb_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      pclk,
    input  logic                      preset,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    input  logic                      pready,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pslverr
);

    localparam int              CNT_W    = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apb_state_e                state_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      rsp_timeout_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      timeout_hit;

    // This wait cycle is the one that would bring the counter to its limit.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr_q  <= cmd_addr;
                        pwrite_q <= cmd_write;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : prdata;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timeout_hit) begin
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign psel        = psel_q;
    assign penable     = penable_q;

endmodule

// File: tb/tb_cfs_apb_master.sv
// Directed bench for cfs_apb_master: each task drives one scenario and checks
// outputs against hand-computed values one time unit after the rising edge.
module tb_cfs_apb_master;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [15:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int vectors;
    int miscompares;

    cfs_apb_master #(
        .APB_ADDR_WIDTH(16),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk       (pclk),
        .preset     (preset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .pwdata     (pwdata),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present one command while IDLE and withdraw it after the accepting edge.
    task automatic accept(input logic w, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout});
        end
        vectors++;
        if ({paddr, pwdata, rsp_rdata} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_data: got paddr=%h pwdata=%h rdata=%h expected zeros",
                     paddr, pwdata, rsp_rdata);
        end
        preset = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
        accept(1'b1, 16'h0000, 32'h0000_0102);
        vectors++;
        if ({psel, penable, pwrite, cmd_ready} !== 4'b1010 || pwdata !== 32'h0000_0102) begin
            miscompares++;
            $display("FAIL write_setup: got sel/en/wr/rdy=%b pwdata=%h expected 1010 00000102",
                     {psel, penable, pwrite, cmd_ready}, pwdata);
        end
        tick();
        vectors++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL write_access: got sel/en/rv=%b expected 110", {psel, penable, rsp_valid});
        end
        tick();
        vectors++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_timeout} !== 5'b00100 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL write_resp: got sel/en/rv/err/to=%b rdata=%h expected 00100 00000000",
                     {psel, penable, rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL write_done: got rv/rdy=%b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_wait();
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
        accept(1'b0, 16'h000C, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            tick();
            vectors++;
            if (paddr !== 16'h000C || {psel, penable, pwrite} !== 3'b110) begin
                miscompares++;
                $display("FAIL read_access_c%0d: got paddr=%h sel/en/wr=%b expected 000c 110",
                         c, paddr, {psel, penable, pwrite});
            end
            if (c == 3) begin
                pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0305;
            end
        end
        tick();
        pready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_0305 || {rsp_err, rsp_timeout} !== 2'b00) begin
            miscompares++;
            $display("FAIL read_resp: got rv=%b rdata=%h err/to=%b expected 1 00000305 00",
                     rsp_valid, rsp_rdata, {rsp_err, rsp_timeout});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_slverr();
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
        accept(1'b1, 16'h0004, 32'hCAFE_0004);
        tick();
        tick();
        pslverr = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL slverr_resp: got rv/err/to=%b rdata=%h expected 110 00000000",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int access_cycles;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h1111_2222;
        accept(1'b0, 16'h0010, 32'h0);
        access_cycles = 0;
        tick();
        while (psel && penable && access_cycles < 40) begin
            access_cycles++;
            tick();
        end
        vectors++;
        if (access_cycles !== 16) begin
            miscompares++;
            $display("FAIL timeout_cycles: got %0d ACCESS cycles expected 16", access_cycles);
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b111 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL timeout_resp: got rv/err/to=%b rdata=%h expected 111 00000000",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // pready arriving in the sixteenth ACCESS cycle beats the timeout.
    task automatic test_pready_at_limit();
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        accept(1'b0, 16'h0020, 32'h0);
        tick();
        for (int c = 1; c < 16; c++) tick();
        pready = 1'b1; prdata = 32'h0000_00A5;
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL limit_still_access: got sel/en=%b expected 11", {psel, penable});
        end
        tick();
        pready = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0000_00A5) begin
            miscompares++;
            $display("FAIL limit_resp: got rv/err/to=%b rdata=%h expected 100 000000a5",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h1234_5678;
        accept(1'b0, 16'h0030, 32'h0);
        tick();
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 32'h0000_0040;
        for (int c = 0; c < 5; c++) begin
            prdata = 32'h9000_0000 + c;
            vectors++;
            if ({rsp_valid, rsp_err, rsp_timeout, cmd_ready, psel} !== 5'b10000 ||
                rsp_rdata !== 32'h1234_5678 || paddr !== 16'h0030) begin
                miscompares++;
                $display("FAIL bp_hold_c%0d: got rv/err/to/rdy/sel=%b rdata=%h paddr=%h expected 10000 12345678 0030",
                         c, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, psel}, rsp_rdata, paddr);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
            miscompares++;
            $display("FAIL bp_release: got rv/rdy/sel=%b expected 010", {rsp_valid, cmd_ready, psel});
        end
        tick();
        cmd_valid = 1'b0;
        vectors++;
        if (psel !== 1'b1 || paddr !== 16'h0040 || pwrite !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_next_setup: got sel=%b paddr=%h wr=%b expected 1 0040 1", psel, paddr, pwrite);
        end
        tick();
        tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rdy_seen;
        logic [7:0] rv_seen;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0; rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 32'h5;
        for (int c = 0; c < 8; c++) begin
            tick();
            rdy_seen[c] = cmd_ready;
            rv_seen[c]  = rsp_valid;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (rdy_seen !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL b2b_cmd_ready: got %b expected 10001000", rdy_seen);
        end
        vectors++;
        if (rv_seen !== 8'b0100_0100) begin
            miscompares++;
            $display("FAIL b2b_rsp_valid: got %b expected 01000100", rv_seen);
        end
    endtask

    task automatic test_reset_mid_access();
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        accept(1'b0, 16'h0060, 32'h0);
        tick();
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        vectors++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0001 || paddr !== 16'h0) begin
            miscompares++;
            $display("FAIL rst_access: got sel/en/rv/rdy=%b paddr=%h expected 0001 0000",
                     {psel, penable, rsp_valid, cmd_ready}, paddr);
        end
        pready = 1'b1; prdata = 32'h0000_0777;
        accept(1'b0, 16'h0070, 32'h0);
        tick();
        tick();
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0000_0777) begin
            miscompares++;
            $display("FAIL rst_recover: got rv/err/to=%b rdata=%h expected 100 00000777",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        preset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;

        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_pready_at_limit();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
